// File: rtl/ehl_rv_arbiter_if.sv
// rtl/ehl_rv_arbiter_if.sv - requester and output-stage signals of the round-robin arbiter
interface ehl_rv_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SW    = 2
);
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_last;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic               out_last;
  logic [SW-1:0]      out_src;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last, out_src
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_src
  );
endinterface

// File: rtl/ehl_rv_arbiter.sv
// rtl/ehl_rv_arbiter.sv - round-robin ready-valid arbiter with a registered output stage
// Optional packet lock is compiled in with EHL_RV_ARB_LOCK_EN.
module ehl_rv_arbiter #(
  parameter int N     = 4,
  parameter int WIDTH = 8,
  parameter int SW    = 2
) (
  input logic             clk,
  input logic             reset_n,
  ehl_rv_arbiter_if.slave bus
);
  logic [SW-1:0]    ptr;
  logic             out_valid_q;
  logic             out_last_q;
  logic [WIDTH-1:0] out_data_q;
  logic [SW-1:0]    out_src_q;

  logic             stage_ready;
  logic [2*N-1:0]   valid_dbl;
  logic [N-1:0]     valid_rot;
  logic [SW-1:0]    offset;
  logic             rr_found;
  logic [SW:0]      grant_sum;
  logic [SW-1:0]    rr_grant;
  logic [SW-1:0]    grant;
  logic             grant_found;
  logic [SW-1:0]    grant_inc;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;
  logic             sel_valid;
  logic             transfer;

  assign stage_ready = !out_valid_q || bus.out_ready;

  // Doubling the valid vector makes the rotation by ptr wrap at N, not at 2^SW.
  assign valid_dbl = {bus.in_valid, bus.in_valid};
  assign valid_rot = valid_dbl[ptr +: N];

  always_comb begin
    offset   = '0;
    rr_found = 1'b0;
    for (int j = N - 1; j >= 0; j--) begin
      if (valid_rot[j]) begin
        offset   = SW'(j);
        rr_found = 1'b1;
      end
    end
  end

  assign grant_sum = {1'b0, ptr} + {1'b0, offset};
  assign rr_grant  = (grant_sum >= (SW+1)'(N)) ? SW'(grant_sum - (SW+1)'(N))
                                               : grant_sum[SW-1:0];

`ifdef EHL_RV_ARB_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_src;

  // A locked packet owns the stage even while its source idles between beats.
  assign grant       = locked ? lock_src : rr_grant;
  assign grant_found = locked || rr_found;
`else
  assign grant       = rr_grant;
  assign grant_found = rr_found;
`endif

  assign grant_inc = (grant == SW'(N - 1)) ? '0 : grant + SW'(1);

  always_comb begin
    sel_data  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant == SW'(i)) begin
        sel_data  = bus.in_data[i*WIDTH +: WIDTH];
        sel_last  = bus.in_last[i];
        sel_valid = bus.in_valid[i];
      end
    end
  end

  always_comb begin
    bus.in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_found && grant == SW'(i)) begin
        bus.in_ready[i] = stage_ready;
      end
    end
  end

  assign transfer = grant_found && sel_valid && stage_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
`ifdef EHL_RV_ARB_LOCK_EN
      locked      <= 1'b0;
      lock_src    <= '0;
`endif
    end else begin
      if (transfer) begin
        out_data_q <= sel_data;
        out_last_q <= sel_last;
        out_src_q  <= grant;
`ifdef EHL_RV_ARB_LOCK_EN
        if (sel_last) begin
          ptr    <= grant_inc;
          locked <= 1'b0;
        end else begin
          locked   <= 1'b1;
          lock_src <= grant;
        end
`else
        ptr <= grant_inc;
`endif
      end
      out_valid_q <= transfer || (out_valid_q && !bus.out_ready);
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_src   = out_src_q;
endmodule

// File: tb/tb_ehl_rv_arbiter.sv
// tb/tb_ehl_rv_arbiter.sv - scoreboard bench for ehl_rv_arbiter (N=4 main instance, N=3 wrap instance)
module tb_ehl_rv_arbiter;
  localparam int WIDTH = 8;
  localparam int SW    = 2;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    src;
    logic             last;
  } beat_t;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;
  beat_t exp_q[$];

  always #5 clk = ~clk;

  ehl_rv_arbiter_if #(.N(4), .WIDTH(WIDTH), .SW(SW)) bus4 ();
  ehl_rv_arbiter_if #(.N(3), .WIDTH(WIDTH), .SW(SW)) bus3 ();

  ehl_rv_arbiter #(.N(4), .WIDTH(WIDTH), .SW(SW)) dut4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus4.slave)
  );

  ehl_rv_arbiter #(.N(3), .WIDTH(WIDTH), .SW(SW)) dut3 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus3.slave)
  );

  // Every beat read from the N=4 instance must be the next expected one.
  always @(negedge clk) begin
    beat_t got;
    beat_t want;
    if (reset_n && bus4.out_valid && bus4.out_ready) begin
      got = {bus4.out_data, bus4.out_src, bus4.out_last};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got data=%h src=%0d last=%0d required no beat",
                 got.data, got.src, got.last);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL sb_beat got data=%h src=%0d last=%0d required data=%h src=%0d last=%0d",
                   got.data, got.src, got.last, want.data, want.src, want.last);
        end
      end
    end
  end

  function automatic void push(input logic [WIDTH-1:0] d, input int s, input logic l);
    beat_t b;
    b.data = d;
    b.src  = SW'(s);
    b.last = l;
    exp_q.push_back(b);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus4.in_valid  = '0;
    bus4.in_data   = '0;
    bus4.in_last   = '0;
    bus4.out_ready = 1'b0;
    bus3.in_valid  = '0;
    bus3.in_data   = '0;
    bus3.in_last   = '0;
    bus3.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_src !== 2'd0 || bus4.out_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_out got valid=%b src=%0d data=%h required 0 0 00",
               bus4.out_valid, bus4.out_src, bus4.out_data);
    end
    checks++;
    if (bus4.in_ready !== 4'b0000) begin
      errors++;
      $display("FAIL reset_in_ready got %b required 0000", bus4.in_ready);
    end
    reset_n = 1'b1;
    step();
    bus4.in_valid = 4'b0100;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0100) begin
      errors++;
      $display("FAIL ready_first_valid got %b required 0100", bus4.in_ready);
    end
    bus4.in_valid = 4'b0110;
    bus4.in_data[1*WIDTH +: WIDTH] = 8'h77;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b0010) begin
      errors++;
      $display("FAIL ready_priority got %b required 0010", bus4.in_ready);
    end
    step();
    bus4.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h77) begin
      errors++;
      $display("FAIL held_before_reset got valid=%b data=%h required 1 77",
               bus4.out_valid, bus4.out_data);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus4.out_valid !== 1'b0 || bus4.out_data !== 8'h00) begin
      errors++;
      $display("FAIL async_reset got valid=%b data=%h required 0 00",
               bus4.out_valid, bus4.out_data);
    end
    step();
    reset_n = 1'b1;
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) bus4.in_data[i*WIDTH +: WIDTH] = 8'hA0 + 8'(i);
    bus4.in_last  = 4'b1111;
    bus4.in_valid = 4'b1111;
    bus4.out_ready = 1'b1;
    push(8'hA0, 0, 1'b1);
    push(8'hA1, 1, 1'b1);
    push(8'hA2, 2, 1'b1);
    push(8'hA3, 3, 1'b1);
    push(8'hA0, 0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (bus4.out_valid !== 1'b1) begin
        errors++;
        $display("FAIL rr_throughput cycle %0d got valid=%b required 1", k, bus4.out_valid);
      end
    end
    bus4.in_valid = '0;
    step();
    step();
    checks++;
    if (bus4.out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL rr_drain got valid=%b pending=%0d required 0 0", bus4.out_valid, exp_q.size());
    end
  endtask

  task automatic test_single_source();
    do_reset();
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 4'b0100;
    push(8'h20, 2, 1'b0);
    push(8'h21, 2, 1'b0);
    push(8'h22, 2, 1'b1);
    for (int k = 0; k < 3; k++) begin
      bus4.in_data[2*WIDTH +: WIDTH] = 8'h20 + 8'(k);
      bus4.in_last[2] = (k == 2);
      step();
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_src !== 2'd2) begin
        errors++;
        $display("FAIL single_beat %0d got valid=%b src=%0d required 1 2", k, bus4.out_valid, bus4.out_src);
      end
    end
    bus4.in_valid = 4'b1111;
    bus4.in_last  = 4'b1111;
    #1;
    checks++;
    if (bus4.in_ready !== 4'b1000) begin
      errors++;
      $display("FAIL ptr_after_single got in_ready=%b required 1000", bus4.in_ready);
    end
    bus4.in_valid = '0;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_drain got pending=%0d required 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus4.in_valid = 4'b0001;
    bus4.in_last  = 4'b0001;
    bus4.in_data[0 +: WIDTH] = 8'h55;
    push(8'h55, 0, 1'b1);
    step();
    bus4.in_data[0 +: WIDTH] = 8'h66;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h55 || bus4.in_ready !== 4'b0000) begin
        errors++;
        $display("FAIL stall %0d got valid=%b data=%h in_ready=%b required 1 55 0000",
                 k, bus4.out_valid, bus4.out_data, bus4.in_ready);
      end
      step();
    end
    bus4.out_ready = 1'b1;
    push(8'h66, 0, 1'b1);
    step();
    bus4.in_valid = '0;
    @(negedge clk);
    checks++;
    if (bus4.out_valid !== 1'b1 || bus4.out_data !== 8'h66) begin
      errors++;
      $display("FAIL release_next got valid=%b data=%h required 1 66", bus4.out_valid, bus4.out_data);
    end
    step();
    checks++;
    if (bus4.out_valid !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL release_drain got valid=%b pending=%0d required 0 0", bus4.out_valid, exp_q.size());
    end
  endtask

  task automatic test_n3_wrap();
    logic [SW-1:0] exp_src [4];
    exp_src = '{2'd0, 2'd2, 2'd0, 2'd2};
    do_reset();
    for (int i = 0; i < 3; i++) bus3.in_data[i*WIDTH +: WIDTH] = 8'h30 + 8'(i);
    bus3.in_last   = 3'b111;
    bus3.in_valid  = 3'b101;
    bus3.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++;
      if (bus3.out_valid !== 1'b1 || bus3.out_src !== exp_src[k]) begin
        errors++;
        $display("FAIL n3_wrap %0d got valid=%b src=%0d required 1 %0d",
                 k, bus3.out_valid, bus3.out_src, exp_src[k]);
      end
    end
    bus3.in_valid = '0;
    step();
  endtask

  task automatic test_packet_lock();
    logic [3:0] hs;
    int         b1;
    b1 = 0;
    do_reset();
    bus4.out_ready = 1'b1;
    bus4.in_valid  = 4'b0001;
    bus4.in_last   = 4'b0001;
    bus4.in_data[0 +: WIDTH] = 8'h0F;
    push(8'h0F, 0, 1'b1);
    step();
    bus4.in_data[0*WIDTH +: WIDTH] = 8'h01;
    bus4.in_data[1*WIDTH +: WIDTH] = 8'h11;
    bus4.in_data[3*WIDTH +: WIDTH] = 8'h30;
    bus4.in_last  = 4'b1001;
    bus4.in_valid = 4'b1011;
`ifdef EHL_RV_ARB_LOCK_EN
    push(8'h11, 1, 1'b0);
    push(8'h12, 1, 1'b0);
    push(8'h13, 1, 1'b1);
    push(8'h30, 3, 1'b1);
`else
    push(8'h11, 1, 1'b0);
    push(8'h30, 3, 1'b1);
    push(8'h01, 0, 1'b1);
    push(8'h12, 1, 1'b0);
`endif
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      hs = bus4.in_valid & bus4.in_ready;
      if (c == 1) begin
        checks++;
`ifdef EHL_RV_ARB_LOCK_EN
        if (bus4.in_ready !== 4'b0010) begin
          errors++;
          $display("FAIL lock_hold got in_ready=%b required 0010", bus4.in_ready);
        end
`else
        if (bus4.in_ready !== 4'b1000) begin
          errors++;
          $display("FAIL interleave got in_ready=%b required 1000", bus4.in_ready);
        end
`endif
      end
      step();
      if (hs[0]) bus4.in_data[0*WIDTH +: WIDTH] = bus4.in_data[0*WIDTH +: WIDTH] + 8'h01;
      if (hs[3]) bus4.in_data[3*WIDTH +: WIDTH] = bus4.in_data[3*WIDTH +: WIDTH] + 8'h01;
      if (hs[1]) begin
        b1++;
        bus4.in_data[1*WIDTH +: WIDTH] = 8'h11 + 8'(b1);
        bus4.in_last[1] = (b1 == 2);
        if (b1 == 3) bus4.in_valid[1] = 1'b0;
      end
    end
    bus4.in_valid = '0;
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL lock_drain got pending=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_source();
    test_backpressure();
    test_n3_wrap();
    test_packet_lock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ehl_rv_arbiter.md
# ehl_rv_arbiter

Round-robin arbiter sharing one registered ready-valid output stage among N ready-valid requesters. Each cycle the output stage can accept a beat, it grants one valid requester, captures that requester's data into the output register and rotates priority. Placed in front of a shared pipeline resource (bus master port, shared FIFO, single datapath engine) fed by several independent ready-valid sources.

## Interface
- N, default 4, number of requesters (2..16).
- WIDTH, default 8, data width per requester.
- SW, default 2, source index width, set by instantiator to clog2(N).

- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  N  per-requester valid, bit i = requester i.
- in_ready  out  N  per-requester ready, at most one bit set.
- in_data  in  N*WIDTH  requester i data at [i*WIDTH +: WIDTH].
- in_last  in  N  per-requester end-of-packet marker.
- out_valid  out  1  output stage holds a beat.
- out_ready  in  1  downstream accepts beat.
- out_data  out  WIDTH  registered data of held beat.
- out_last  out  1  registered last marker of held beat.
- out_src  out  SW  index of requester that produced held beat.

## Operation
- stage_ready = !out_valid | out_ready (empty or being read), combinational.
- Round-robin pointer ptr (SW bits) names highest-priority requester; search order ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
- Grant g = first i in search order with in_valid[i]=1; no valid requester -> no grant.
- in_ready[g] = stage_ready; all other in_ready bits 0. in_ready[i] never depends on in_valid[i] of same requester beyond grant selection.
- Transfer: in_valid[g] & in_ready[g]. On transfer: out_data <= in_data[g], out_last <= in_last[g], out_src <= g, out_valid <= 1.
- out_valid next = transfer | (out_valid & !out_ready).
- Pointer update on transfer: ptr <= g+1, wrapping N-1 -> 0 (non-power-of-two N wraps at N, not 2^SW).
- No transfer: ptr, out_data, out_last, out_src hold.
- Requester with in_valid=1 and no grant must hold data stable (standard ready-valid rule); arbiter never drops or duplicates a beat.
- Fairness: any continuously valid requester is granted within N transfers.

## Timing
- Reset values: out_valid=0, out_data=0, out_last=0, out_src=0, ptr=0; in_ready then equals one-hot of first valid requester from 0.
- Latency: input beat appears at output one cycle after transfer.
- Throughput: one beat per cycle when out_ready held 1 (read and write same cycle).
- Backpressure: out_valid=1 & out_ready=0 -> all in_ready=0, output held.
- Simultaneous requests: lowest search-order index wins; losers see in_ready=0.
- Reset mid-operation: held beat discarded, out_valid falls asynchronously to 0, lock (if compiled) cleared.
- in_ready is combinational from out_ready and in_valid; no combinational path from in_data to any output.

## Configuration
- Macro EHL_RV_ARB_LOCK_EN.
- Defined: packet lock. Transfer with in_last=0 sets lock, lock_src <= g. While locked, grant forced to lock_src regardless of priority; other requesters in_ready=0 even if lock_src has in_valid=0. Transfer with in_last=1 clears lock and advances ptr to lock_src+1. ptr does not advance on non-last beats. Lock reset value 0.
- Undefined: arbitration per beat as above; in_last only carried to out_last, packets from different requesters may interleave.

## Test plan
- Reset, N=4, all in_valid=0 -> out_valid=0, in_ready=0000, out_src=0; reset asserted with beat held -> out_valid=0 immediately.
- in_valid=1111, out_ready=1, data i=0xA0+i, constant -> out_data sequence A0,A1,A2,A3,A0, one per cycle, out_src 0,1,2,3,0.
- Only requester 2 valid, 3 beats, out_ready=1 -> 3 consecutive beats, out_src=2, then ptr=3.
- out_ready=0 for 5 cycles with beat 0x55 held -> out_data stays 0x55, in_ready=0000; release -> 0x55 read once, next beat follows next cycle.
- N=3, requesters 0,2 valid -> grants alternate 0,2,0,2 (pointer wraps 2 -> 0).
- With EHL_RV_ARB_LOCK_EN, requester 1 sends 3-beat packet (last on beat 3) while 0 and 3 valid -> three out_src=1 beats uninterrupted, then 3 granted; without macro -> 1,3,0,1 interleave.
